// File: rtl/div_if.sv
// div_if: request/result bundle between the execute stage and div_unit
interface div_if #(parameter int DATA_WIDTH = 32);
   logic                  start;
   logic                  is_signed;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] Quotient;
   logic [DATA_WIDTH-1:0] Remainder;
   logic                  DivZero;
   logic                  Overflow;
   logic                  Zero;
   modport master (
      output start, is_signed, A, B,
      input  busy, done, Quotient, Remainder, DivZero, Overflow, Zero
   );
   modport slave (
      input  start, is_signed, A, B,
      output busy, done, Quotient, Remainder, DivZero, Overflow, Zero
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring integer divider, signed or unsigned, one quotient bit per cycle
module div_unit #(parameter int DATA_WIDTH = 32) (
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);
   localparam int W = DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
   state_t       state;
   logic [W-1:0] a_reg, b_reg, dvd, rem, bm, cnt;
   logic         sgn, qneg, rneg;
   logic         a_neg, b_neg, ovf;
   logic [W:0]   sh, trial;
   logic [W-1:0] q_fin, r_fin;
   assign a_neg = bus.is_signed & bus.A[W-1];
   assign b_neg = bus.is_signed & bus.B[W-1];
   assign sh    = {rem, dvd[W-1]};
   assign trial = sh - {1'b0, bm};
   assign q_fin = qneg ? -dvd : dvd;
   assign r_fin = rneg ? -rem : rem;
   assign ovf   = sgn && a_reg == {1'b1, {(W-1){1'b0}}} && b_reg == '1;
   // control FSM, iteration datapath and registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         dvd           <= '0;
         rem           <= '0;
         bm            <= '0;
         cnt           <= '0;
         sgn           <= 1'b0;
         qneg          <= 1'b0;
         rneg          <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.Quotient  <= '0;
         bus.Remainder <= '0;
         bus.DivZero   <= 1'b0;
         bus.Overflow  <= 1'b0;
         bus.Zero      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_reg        <= bus.A;
                  b_reg        <= bus.B;
                  sgn          <= bus.is_signed;
                  qneg         <= a_neg ^ b_neg;
                  rneg         <= a_neg;
                  dvd          <= a_neg ? -bus.A : bus.A;
                  bm           <= b_neg ? -bus.B : bus.B;
                  rem          <= '0;
                  cnt          <= '0;
                  bus.busy     <= 1'b1;
                  bus.DivZero  <= 1'b0;
                  bus.Overflow <= 1'b0;
                  state        <= bus.B == '0 ? FINISH : RUN;
               end
            end
            RUN: begin
               dvd   <= {dvd[W-2:0], ~trial[W]};
               rem   <= trial[W] ? sh[W-1:0] : trial[W-1:0];
               cnt   <= cnt + 1'b1;
               state <= cnt == W'(W - 1) ? FINISH : RUN;
            end
            default: begin
               bus.Quotient  <= b_reg == '0 ? '1 : q_fin;
               bus.Remainder <= b_reg == '0 ? a_reg : r_fin;
               bus.Zero      <= b_reg != '0 && q_fin == '0;
               bus.DivZero   <= b_reg == '0;
               bus.Overflow  <= b_reg != '0 && ovf;
               bus.done      <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc = 0;
   int   dones = 0;
   div_if #(.DATA_WIDTH(32)) bus ();
   div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // free-running cycle counter used to measure latency
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(negedge clk);
      bus.A = a;
      bus.B = b;
      bus.is_signed = s;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      acc = cyc;
      chk("busy after accept", {31'b0, bus.busy}, 32'd1);
   endtask
   task automatic wait_done(input int lat, input string tag);
      int n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, cyc - acc, lat);
      chk({tag, " busy at done"}, {31'b0, bus.busy}, 32'd0);
      @(negedge clk);
      chk({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
   endtask
   task automatic res(input string tag, input logic [31:0] q, input logic [31:0] r,
                      input logic dz, input logic ov, input logic z);
      chk({tag, " quotient"}, bus.Quotient, q);
      chk({tag, " remainder"}, bus.Remainder, r);
      chk({tag, " divzero"}, {31'b0, bus.DivZero}, {31'b0, dz});
      chk({tag, " overflow"}, {31'b0, bus.Overflow}, {31'b0, ov});
      chk({tag, " zero"}, {31'b0, bus.Zero}, {31'b0, z});
   endtask
   initial begin
      bus.start = 1'b0;
      bus.is_signed = 1'b0;
      bus.A = '0;
      bus.B = '0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset busy", {31'b0, bus.busy}, 32'd0);
      chk("reset done", {31'b0, bus.done}, 32'd0);
      res("reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      issue(32'd100, 32'd7, 1'b0);
      wait_done(33, "u100/7");
      res("u100/7", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
      issue(32'hFFFFFFF9, 32'd2, 1'b1);
      wait_done(33, "s-7/2");
      res("s-7/2", 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      issue(32'hFFFFFFF9, 32'd2, 1'b0);
      wait_done(33, "uFFFFFFF9/2");
      res("uFFFFFFF9/2", 32'h7FFFFFFC, 32'd1, 1'b0, 1'b0, 1'b0);
      issue(32'h12345678, 32'd0, 1'b0);
      wait_done(1, "u/0");
      res("u/0", 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 1'b0);
      issue(32'hFFFFFFF9, 32'd0, 1'b1);
      wait_done(1, "s/0");
      res("s/0", 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 1'b0);
      issue(32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_done(33, "sovf");
      res("sovf", 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0);
      issue(32'd5, 32'd9, 1'b1);
      wait_done(33, "s5/9");
      res("s5/9", 32'h0, 32'd5, 1'b0, 1'b0, 1'b1);
      issue(32'd7, 32'hFFFFFFFE, 1'b1);
      wait_done(33, "s7/-2");
      res("s7/-2", 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 1'b0);
      issue(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1);
      wait_done(33, "s-7/-2");
      res("s-7/-2", 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      issue(32'd100, 32'd7, 1'b0);
      while (cyc < acc + 5) @(negedge clk);
      bus.A = 32'd1000;
      bus.B = 32'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < acc + 20) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(33, "ignored start");
      res("ignored start", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);
      issue(32'd1000, 32'd3, 1'b0);
      wait_done(33, "u1000/3");
      res("u1000/3", 32'd333, 32'd1, 1'b0, 1'b0, 1'b0);
      issue(32'hFFFFFFFF, 32'd16, 1'b0);
      while (cyc < acc + 10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrun reset busy", {31'b0, bus.busy}, 32'd0);
      chk("midrun reset done", {31'b0, bus.done}, 32'd0);
      res("midrun reset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      chk("aborted op done count", dones, 0);
      issue(32'hFFFFFFFF, 32'd16, 1'b0);
      wait_done(33, "after reset");
      res("after reset", 32'h0FFFFFFF, 32'd15, 1'b0, 1'b0, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
